// File: rtl/riscv_pkg.sv
// Architectural register constants shared by decode and the register file.
package riscv_pkg;

  localparam int REGISTER_COUNT       = 32;
  localparam int REGISTER_INDEX_WIDTH = $clog2(REGISTER_COUNT);

  typedef logic [REGISTER_INDEX_WIDTH-1:0] reg_idx_t;

  localparam reg_idx_t X0 = '0;

  // x0 and indices beyond the implemented registers never hold state.
  function automatic logic idx_writable(input int idx, input int num_regs);
    return (idx != 0) && (idx < num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with reserve-over-clear priority and a registered busy population count.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = REGISTER_COUNT,
  parameter int NUM_WR   = 2,
  localparam int IDXW    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rsv_en,
  input  logic [IDXW-1:0]            rsv_addr,
  input  logic [NUM_WR-1:0]          clr_en,
  input  logic [NUM_WR-1:0][IDXW-1:0] clr_addr,
  output logic [NUM_REGS-1:0]        busy,
  output logic [IDXW:0]              busy_count
);

  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic [IDXW:0]       count_d, count_q;

  // A new producer reserving a register outranks a writeback retiring it in the same cycle.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (clr_en[p] && (int'(clr_addr[p]) == r)) begin
          busy_d[r] = 1'b0;
        end
      end
      if (rsv_en && (int'(rsv_addr) == r)) begin
        busy_d[r] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;

    count_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d = count_d + (IDXW+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = count_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with busy scoreboard; define REGFILE_BYPASS_EN for same-cycle
// write-through on the read ports.
module regfile_mp_sb
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = REGISTER_COUNT,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  localparam int IDXW    = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD-1:0][IDXW-1:0] rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]           rd_busy,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR-1:0][IDXW-1:0] wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0] wr_data,
  input  logic                        rsv_en,
  input  logic [IDXW-1:0]             rsv_addr,
  output logic [IDXW:0]               busy_count
);

  logic [NUM_REGS-1:0][XLEN-1:0] regs_d, regs_q;
  logic [NUM_REGS-1:0]           busy;
  logic [NUM_WR-1:0]             wr_valid;

  always_comb begin
    wr_valid = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_valid[p] = wr_en[p] && idx_writable(int'(wr_addr[p]), NUM_REGS);
    end
  end

  // Ports are scanned low to high so the highest-index writer to an address wins.
  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_valid[p] && (int'(wr_addr[p]) == r)) begin
          regs_d[r] = wr_data[p];
        end
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rsv_en     (rsv_en && idx_writable(int'(rsv_addr), NUM_REGS)),
    .rsv_addr   (rsv_addr),
    .clr_en     (wr_valid),
    .clr_addr   (wr_addr),
    .busy       (busy),
    .busy_count (busy_count)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (int'(rd_addr[i]) < NUM_REGS) begin
        rd_data[i] = regs_q[rd_addr[i]];
        rd_busy[i] = busy[rd_addr[i]];
      end
`ifdef REGFILE_BYPASS_EN
      // A same-cycle reservation keeps the register pending, so busy is not masked then.
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_valid[p] && (wr_addr[p] == rd_addr[i])) begin
          rd_data[i] = wr_data[p];
          if (!(rsv_en && (rsv_addr == rd_addr[i]))) begin
            rd_busy[i] = 1'b0;
          end
        end
      end
`endif
    end
  end

endmodule
